// File: rtl/layer_sequencer_pkg.sv
// Shared definitions for the layer sequencer: compute-select encodings,
// descriptor type enum, FSM state enum, buffer-mode constants and small
// decode helpers used by the sequencer top and its descriptor FIFO.
package layer_sequencer_pkg;

    localparam logic [2:0] COMP_IDLE  = 3'b000;
    localparam logic [2:0] COMP_CONV  = 3'b001;
    localparam logic [2:0] COMP_DENSE = 3'b010;
    localparam logic [2:0] COMP_POOL  = 3'b011;

    // {dense, ping}: idle mode has BUF1 driving the PE array
    localparam logic [1:0] MODE_IDLE = 2'b01;

    typedef enum logic [1:0] {
        CFG_INVALID = 2'b00,
        CFG_CONV    = 2'b01,
        CFG_DENSE   = 2'b10,
        CFG_POOL    = 2'b11
    } cfg_type_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

    typedef struct packed {
        cfg_type_e ltype;
        logic      last;
    } layer_desc_t;

    function automatic logic [2:0] type_to_comp(input cfg_type_e t);
        case (t)
            CFG_CONV:  return COMP_CONV;
            CFG_DENSE: return COMP_DENSE;
            CFG_POOL:  return COMP_POOL;
            default:   return COMP_IDLE;
        endcase
    endfunction

    // Engine start/done bit order is {pool, dense, conv}
    function automatic logic [2:0] type_to_onehot(input cfg_type_e t);
        case (t)
            CFG_CONV:  return 3'b001;
            CFG_DENSE: return 3'b010;
            CFG_POOL:  return 3'b100;
            default:   return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/layer_desc_fifo.sv
// Synchronous FIFO holding layer descriptors.
// Ports: clk/rst_n, push_i + wdata_i (write), pop_i (read request),
// rdata_o (head entry, valid while !empty_o), empty_o, ready_o (accepts a
// push this cycle: not full, or full with a simultaneous pop).
module layer_desc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             ready_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             full, pop_ok, push_ok;

    assign full    = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign pop_ok  = pop_i && !empty_o;
    // A pop frees the slot in the same cycle, so a full FIFO can still take a push
    assign ready_o = !full || pop_ok;
    assign push_ok = push_i && ready_o;
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) count_d = count_q + (AW+1)'(1);
        if (!push_ok && pop_ok) count_d = count_q - (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/layer_sequencer.sv
// Layer sequencer: queues layer descriptors and walks them through the
// CONV/DENSE/POOL engines, steering the buffer/PE-array mux and ping-pong.
// Ports: cfg_valid/cfg_ready/cfg_type/cfg_last (descriptor push),
// run_start (begin network), comp_sel/aybz_azby (mux control),
// eng_start/eng_done (one-hot engine handshake {pool,dense,conv}),
// busy, net_done, layer_cnt, err (status).
//
// state | meaning
// IDLE  | waiting for run_start, mux parked
// LOAD  | pop next descriptor (waits while queue empty)
// START | comp_sel already set; issue engine start pulse
// RUN   | engine working, wait for its done bit
// DRAIN | hold mux DRAIN_CYC cycles, then count layer and swap ping
module layer_sequencer
    import layer_sequencer_pkg::*;
#(
    parameter int QDEPTH    = 4,
    parameter int DRAIN_CYC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [1:0] cfg_type,
    input  logic       cfg_last,
    input  logic       run_start,
    output logic [2:0] comp_sel,
    output logic [1:0] aybz_azby,
    output logic [2:0] eng_start,
    input  logic [2:0] eng_done,
    output logic       busy,
    output logic       net_done,
    output logic [7:0] layer_cnt,
    output logic       err
);

    state_e      state_q;
    layer_desc_t cur_desc_q, head_desc, push_desc;
    logic        ping_q;
    logic [3:0]  drain_cnt_q;
    logic [2:0]  comp_sel_q, eng_start_q;
    logic [1:0]  aybz_q;
    logic        busy_q, net_done_q, err_q;
    logic [7:0]  layer_cnt_q;
    logic        fifo_empty, fifo_pop;
    logic [2:0]  cur_onehot;

    assign push_desc  = '{ltype: cfg_type_e'(cfg_type), last: cfg_last};
    assign fifo_pop   = (state_q == ST_LOAD) && !fifo_empty;
    assign cur_onehot = type_to_onehot(cur_desc_q.ltype);

    layer_desc_fifo #(
        .DEPTH(QDEPTH),
        .WIDTH($bits(layer_desc_t))
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (cfg_valid),
        .wdata_i (push_desc),
        .pop_i   (fifo_pop),
        .rdata_o (head_desc),
        .empty_o (fifo_empty),
        .ready_o (cfg_ready)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cur_desc_q  <= '{ltype: CFG_INVALID, last: 1'b0};
            ping_q      <= 1'b1;
            drain_cnt_q <= '0;
            comp_sel_q  <= COMP_IDLE;
            aybz_q      <= MODE_IDLE;
            eng_start_q <= '0;
            busy_q      <= 1'b0;
            net_done_q  <= 1'b0;
            layer_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            net_done_q  <= 1'b0;
            eng_start_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (run_start) begin
                        state_q     <= ST_LOAD;
                        ping_q      <= 1'b1;
                        layer_cnt_q <= '0;
                        err_q       <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (!fifo_empty) begin
                        cur_desc_q <= head_desc;
                        if (head_desc.ltype == CFG_INVALID) begin
                            err_q <= 1'b1;
                            if (head_desc.last) begin
                                state_q    <= ST_IDLE;
                                net_done_q <= 1'b1;
                                busy_q     <= 1'b0;
                            end
                        end else begin
                            comp_sel_q <= type_to_comp(head_desc.ltype);
                            aybz_q     <= {head_desc.ltype == CFG_DENSE, ping_q};
                            state_q    <= ST_START;
                        end
                    end
                end
                ST_START: begin
                    eng_start_q <= cur_onehot;
                    state_q     <= ST_RUN;
                end
                ST_RUN: begin
                    // A done coinciding with the start pulse cannot belong to this layer
                    if (eng_start_q == 3'b000) begin
                        if ((eng_done & ~cur_onehot) != 3'b000) err_q <= 1'b1;
                        if ((eng_done & cur_onehot) != 3'b000) begin
                            state_q     <= ST_DRAIN;
                            drain_cnt_q <= 4'(DRAIN_CYC - 1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_q == 4'd0) begin
                        layer_cnt_q <= layer_cnt_q + 8'd1;
                        // Dense reads and writes the same buffer, so no ping-pong swap
                        if (cur_desc_q.ltype != CFG_DENSE) ping_q <= ~ping_q;
                        comp_sel_q <= COMP_IDLE;
                        aybz_q     <= MODE_IDLE;
                        if (cur_desc_q.last) begin
                            state_q    <= ST_IDLE;
                            net_done_q <= 1'b1;
                            busy_q     <= 1'b0;
                        end else begin
                            state_q <= ST_LOAD;
                        end
                    end else begin
                        drain_cnt_q <= drain_cnt_q - 4'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign comp_sel  = comp_sel_q;
    assign aybz_azby = aybz_q;
    assign eng_start = eng_start_q;
    assign busy      = busy_q;
    assign net_done  = net_done_q;
    assign layer_cnt = layer_cnt_q;
    assign err       = err_q;

endmodule

// File: tb/tb_layer_sequencer.sv
module tb_layer_sequencer;

    localparam int QDEPTH    = 4;
    localparam int DRAIN_CYC = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [1:0] cfg_type = 2'b00;
    logic       cfg_last = 1'b0;
    logic       run_start = 1'b0;
    logic [2:0] comp_sel;
    logic [1:0] aybz_azby;
    logic [2:0] eng_start;
    logic [2:0] eng_done;
    logic [2:0] auto_done = 3'b000;
    logic [2:0] man_done = 3'b000;
    logic       busy, net_done, err;
    logic [7:0] layer_cnt;

    assign eng_done = auto_done | man_done;

    always #5 clk = ~clk;

    layer_sequencer #(.QDEPTH(QDEPTH), .DRAIN_CYC(DRAIN_CYC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_type  (cfg_type),
        .cfg_last  (cfg_last),
        .run_start (run_start),
        .comp_sel  (comp_sel),
        .aybz_azby (aybz_azby),
        .eng_start (eng_start),
        .eng_done  (eng_done),
        .busy      (busy),
        .net_done  (net_done),
        .layer_cnt (layer_cnt),
        .err       (err)
    );

    typedef struct {logic [1:0] t; bit last;} desc_t;
    typedef struct {logic [2:0] comp; logic [1:0] mode; logic [2:0] start;} eng_exp_t;
    typedef struct {logic [7:0] cnt; logic err;} done_exp_t;

    eng_exp_t  eng_q[$];
    done_exp_t done_q[$];
    int n_checks = 0;
    int n_fail = 0;
    int n_done_seen = 0;
    int n_start_seen = 0;
    int exp_done_total = 0;
    bit auto_resp = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference: walk the descriptor list in order; invalid entries flag
    // error, valid ones run on the engine chosen by type; ping starts at 1
    // and flips after every non-dense layer.
    task automatic model_push(input desc_t list[$], input bit extra_err);
        bit ping = 1'b1;
        int cnt = 0;
        bit e = extra_err;
        eng_exp_t x;
        done_exp_t d;
        foreach (list[i]) begin
            if (list[i].t == 2'b00) begin
                e = 1'b1;
            end else begin
                x.comp  = 3'(list[i].t);
                x.mode  = {list[i].t == 2'b10, ping};
                x.start = 3'(1 << (int'(list[i].t) - 1));
                eng_q.push_back(x);
                cnt++;
                if (list[i].t != 2'b10) ping = !ping;
            end
            if (list[i].last) begin
                d.cnt = 8'(cnt);
                d.err = e;
                done_q.push_back(d);
                exp_done_total++;
                break;
            end
        end
    endtask

    task automatic push(input logic [1:0] t, input bit l);
        bit rdy;
        int g = 0;
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_type  = t;
        cfg_last  = l;
        do begin
            #1 rdy = cfg_ready;
            @(negedge clk);
            g++;
        end while (!rdy && g < 500);
        cfg_valid = 1'b0;
        if (!rdy) check("push_timeout", 32'(rdy), 32'd1);
    endtask

    task automatic pulse_run();
        @(negedge clk);
        run_start = 1'b1;
        @(negedge clk);
        run_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int g = 0;
        while (n_done_seen < exp_done_total && g < 3000) begin
            @(negedge clk);
            g++;
        end
        check(name, n_done_seen, exp_done_total);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_start();
        int g = 0;
        while (eng_start == 3'b000 && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("wait_eng_start", 32'(eng_start != 3'b000), 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_comp_sel"}, comp_sel, 3'b000);
        check({tag, "_aybz"}, aybz_azby, 2'b01);
        check({tag, "_eng_start"}, eng_start, 3'b000);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_net_done"}, net_done, 1'b0);
        check({tag, "_layer_cnt"}, layer_cnt, 8'd0);
        check({tag, "_err"}, err, 1'b0);
        check({tag, "_cfg_ready"}, cfg_ready, 1'b1);
    endtask

    // Monitor: every engine start and every net_done is matched against the
    // next expected entry of its queue.
    initial begin : monitor
        eng_exp_t  e;
        done_exp_t d;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (eng_start != 3'b000) begin
                    n_start_seen++;
                    if (eng_q.size() == 0) begin
                        check("unexpected_eng_start", eng_start, 3'b000);
                    end else begin
                        e = eng_q.pop_front();
                        check("comp_sel", comp_sel, e.comp);
                        check("aybz_azby", aybz_azby, e.mode);
                        check("eng_start", eng_start, e.start);
                        check("busy_run", busy, 1'b1);
                    end
                end
                if (net_done) begin
                    n_done_seen++;
                    if (done_q.size() == 0) begin
                        check("unexpected_net_done", net_done, 1'b0);
                    end else begin
                        d = done_q.pop_front();
                        check("layer_cnt", layer_cnt, d.cnt);
                        check("err_at_done", err, d.err);
                        check("busy_at_done", busy, 1'b0);
                        check("comp_sel_at_done", comp_sel, 3'b000);
                    end
                end
            end
        end
    end

    // Engine model: answers each start with its own done bit after 1..4 cycles
    initial begin : responder
        logic [2:0] b;
        int dly;
        forever begin
            @(negedge clk);
            if (auto_resp && rst_n && eng_start != 3'b000) begin
                b = eng_start;
                dly = $urandom_range(1, 4);
                repeat (dly) @(negedge clk);
                auto_done = b;
                @(negedge clk);
                auto_done = 3'b000;
            end
        end
    end

    initial begin : main
        desc_t list[$];
        desc_t dd;
        int n, saved;

        #23;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // CONV, POOL, DENSE(last) with run_start -> first eng_start latency
        list = '{'{2'b01, 1'b0}, '{2'b11, 1'b0}, '{2'b10, 1'b1}};
        model_push(list, 1'b0);
        foreach (list[i]) push(list[i].t, list[i].last);
        @(negedge clk);
        run_start = 1'b1;
        @(negedge clk);
        run_start = 1'b0;
        check("lat_c1_eng_start", eng_start, 3'b000);
        @(negedge clk);
        check("lat_c2_eng_start", eng_start, 3'b000);
        check("lat_c2_comp_sel", comp_sel, 3'b001);
        @(negedge clk);
        check("lat_c3_eng_start", eng_start, 3'b001);
        wait_done("basic_done");
        check("basic_layer_cnt", layer_cnt, 8'd3);

        // Full queue: 4 accepted, 5th stalls until a pop in LOAD frees a slot
        list.delete();
        for (int i = 0; i < QDEPTH; i++) begin
            dd.t = 2'($urandom_range(1, 3));
            dd.last = 1'b0;
            list.push_back(dd);
        end
        dd.t = 2'b01;
        dd.last = 1'b1;
        list.push_back(dd);
        model_push(list, 1'b0);
        for (int i = 0; i < QDEPTH; i++) push(list[i].t, list[i].last);
        #1 check("full_cfg_ready", cfg_ready, 1'b0);
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_type  = 2'b01;
        cfg_last  = 1'b1;
        #1 check("full_5th_ready_a", cfg_ready, 1'b0);
        @(negedge clk);
        check("full_5th_ready_b", cfg_ready, 1'b0);
        run_start = 1'b1;
        @(negedge clk);
        run_start = 1'b0;
        check("pop_restores_ready", cfg_ready, 1'b1);
        @(negedge clk);
        cfg_valid = 1'b0;
        wait_done("full_done");
        check("full_layer_cnt", layer_cnt, 8'd5);

        // Empty queue at run_start, CONV(last) pushed later
        list = '{'{2'b01, 1'b1}};
        model_push(list, 1'b0);
        pulse_run();
        for (int i = 0; i < 4; i++) begin
            check("empty_comp_sel", comp_sel, 3'b000);
            check("empty_busy", busy, 1'b1);
            @(negedge clk);
        end
        cfg_valid = 1'b1;
        cfg_type  = 2'b01;
        cfg_last  = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        check("late_p1_eng_start", eng_start, 3'b000);
        @(negedge clk);
        check("late_p2_eng_start", eng_start, 3'b000);
        @(negedge clk);
        check("late_p3_eng_start", eng_start, 3'b001);
        wait_done("late_done");

        // Wrong engine done while running CONV, then the right one and drain hold
        auto_resp = 1'b0;
        list = '{'{2'b01, 1'b1}};
        model_push(list, 1'b1);
        push(2'b01, 1'b1);
        pulse_run();
        wait_start();
        @(negedge clk);
        man_done = 3'b010;
        @(negedge clk);
        man_done = 3'b000;
        check("wrong_done_err", err, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("wrong_done_still_run", comp_sel, 3'b001);
            check("wrong_done_no_net", net_done, 1'b0);
            @(negedge clk);
        end
        man_done = 3'b001;
        for (int i = 0; i < DRAIN_CYC; i++) begin
            @(negedge clk);
            man_done = 3'b000;
            check("drain_hold_comp_sel", comp_sel, 3'b001);
            check("drain_hold_aybz", aybz_azby, 2'b01);
        end
        @(negedge clk);
        check("drain_end_comp_sel", comp_sel, 3'b000);
        check("drain_end_net_done", net_done, 1'b1);
        auto_resp = 1'b1;
        wait_done("wrong_done_done");

        // Invalid descriptor is skipped and flagged
        list = '{'{2'b00, 1'b0}, '{2'b01, 1'b1}};
        model_push(list, 1'b0);
        foreach (list[i]) push(list[i].t, list[i].last);
        pulse_run();
        wait_done("invalid_done");

        // Reset during RUN
        auto_resp = 1'b0;
        list = '{'{2'b11, 1'b1}};
        model_push(list, 1'b0);
        push(2'b11, 1'b1);
        pulse_run();
        wait_start();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("mid_run_reset");
        eng_q.delete();
        done_q.delete();
        exp_done_total = n_done_seen;
        saved = n_start_seen;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("no_start_after_reset", n_start_seen, saved);
        check("no_busy_after_reset", busy, 1'b0);
        auto_resp = 1'b1;

        // Randomised networks
        for (int r = 0; r < 25; r++) begin
            list.delete();
            n = $urandom_range(1, 7);
            for (int i = 0; i < n; i++) begin
                dd.t = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
                dd.last = (i == n - 1);
                list.push_back(dd);
            end
            model_push(list, 1'b0);
            for (int i = 0; i < n && i < QDEPTH; i++) push(list[i].t, list[i].last);
            pulse_run();
            for (int i = QDEPTH; i < n; i++) push(list[i].t, list[i].last);
            wait_done("rand_done");
        end

        check("eng_q_drained", eng_q.size(), 0);
        check("done_q_drained", done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
